// File: rtl/eth_speed_pkg.sv
// eth_speed_pkg: speed encodings and measurement result codes shared by the RGMII/GMII speed logic.
package eth_speed_pkg;

    localparam logic [1:0] SPEED_10M   = 2'b00;
    localparam logic [1:0] SPEED_100M  = 2'b01;
    localparam logic [1:0] SPEED_1000M = 2'b10;

    // Speed results share their low bits with the matching speed encoding.
    typedef enum logic [2:0] {
        RES_10M   = 3'd0,
        RES_100M  = 3'd1,
        RES_1000M = 3'd2,
        RES_LOST  = 3'd3,
        RES_NONE  = 3'd4
    } res_t;

endpackage

// File: rtl/eth_sync_bit.sv
// eth_sync_bit: multi-flop synchronizer for a single asynchronous bit; exposes the last two stages.
module eth_sync_bit #(
    parameter int DEPTH = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q,
    output logic o_q_prev
);

    logic [DEPTH-1:0] r_chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_chain <= '0;
        else        r_chain <= {r_chain[DEPTH-2:0], i_d};
    end

    assign o_q      = r_chain[DEPTH-1];
    assign o_q_prev = r_chain[DEPTH-2];

endmodule

// File: rtl/eth_rgmii_speed_detect.sv
// eth_rgmii_speed_detect: measures the PHY rx toggle rate against clk and commits 10M/100M/1000M with hysteresis.
// Define ETH_SPEED_DETECT_LOSS_EN to classify edgeless windows as clock loss and drive link_lost.
module eth_rgmii_speed_detect
    import eth_speed_pkg::*;
#(
    parameter int REF_WIDTH    = 7,
    parameter int EDGE_WIDTH   = 2,
    parameter int STABLE_COUNT = 2,
    parameter int SYNC_STAGES  = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       meas_toggle,
    output logic [1:0] speed,
    output logic       mii_select,
    output logic       speed_valid,
    output logic       speed_change,
    output logic       link_lost
);

    localparam int AW = $clog2(STABLE_COUNT + 1);

    logic                  w_sync, w_sync_prev, w_edge;
    logic                  w_edge_end, w_ref_end, w_end, w_commit;
    logic [REF_WIDTH-1:0]  r_ref_cnt;
    logic [EDGE_WIDTH-1:0] r_edge_cnt;
    logic [AW-1:0]         r_agree, w_agree_next;
    res_t                  r_cand, r_committed, w_res;

    eth_sync_bit #(.DEPTH(SYNC_STAGES)) u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_d      (meas_toggle),
        .o_q      (w_sync),
        .o_q_prev (w_sync_prev)
    );

    assign w_edge     = w_sync ^ w_sync_prev;
    assign w_edge_end = &r_edge_cnt;
    assign w_ref_end  = &r_ref_cnt;
    assign w_end      = w_edge_end | w_ref_end;

    // Edge-count completion wins over a simultaneous reference overflow.
    always_comb begin
        w_res = RES_10M;
`ifdef ETH_SPEED_DETECT_LOSS_EN
        w_res = w_edge_end ? ((|r_ref_cnt[REF_WIDTH-1 -: 2]) ? RES_100M : RES_1000M)
                           : ((r_edge_cnt == '0) ? RES_LOST : RES_10M);
`else
        w_res = w_edge_end ? ((|r_ref_cnt[REF_WIDTH-1 -: 2]) ? RES_100M : RES_1000M) : RES_10M;
`endif
        w_agree_next = (w_res == r_cand) ? ((r_agree == AW'(STABLE_COUNT)) ? r_agree : r_agree + 1'b1)
                                         : AW'(1);
        w_commit = w_end && (w_agree_next == AW'(STABLE_COUNT)) && (w_res != r_committed);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ref_cnt    <= '0;
            r_edge_cnt   <= '0;
            r_cand       <= RES_NONE;
            r_agree      <= '0;
            r_committed  <= RES_NONE;
            speed        <= SPEED_1000M;
            mii_select   <= 1'b0;
            speed_valid  <= 1'b0;
            speed_change <= 1'b0;
        end else if (!enable) begin
            r_ref_cnt    <= '0;
            r_edge_cnt   <= '0;
            r_cand       <= RES_NONE;
            r_agree      <= '0;
            speed_change <= 1'b0;
        end else begin
            speed_change <= w_commit;
            r_ref_cnt    <= w_end ? '0 : r_ref_cnt + 1'b1;
            r_edge_cnt   <= w_end ? '0 : r_edge_cnt + EDGE_WIDTH'(w_edge);
            if (w_end) begin
                r_cand  <= w_res;
                r_agree <= w_agree_next;
            end
            if (w_commit) begin
                r_committed <= w_res;
                speed_valid <= w_res != RES_LOST;
                if (w_res != RES_LOST) begin
                    speed      <= w_res[1:0];
                    mii_select <= w_res != RES_1000M;
                end
            end
        end
    end

`ifdef ETH_SPEED_DETECT_LOSS_EN
    logic r_link_lost;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                   r_link_lost <= 1'b0;
        else if (enable && w_commit)  r_link_lost <= w_res == RES_LOST;
    end

    assign link_lost = r_link_lost;
`else
    assign link_lost = 1'b0;
`endif

endmodule

// File: doc/eth_rgmii_speed_detect.md
# eth_rgmii_speed_detect

Parametrised PHY link-speed detector for the RGMII/GMII MAC wrappers. It samples a divided receive-clock toggle from the PHY clock domain and measures its edge rate against the local reference clock. Each measurement is classified as 10M, 100M or 1000M, and a result is committed only after a configurable number of consecutive agreeing measurements. The committed speed drives `speed` and `mii_select` for the PHY interface and the MAC, replacing the inline detector with a reusable block that adds hysteresis, a validity flag, change pulses and optional clock-loss detection.

## Interface
- `REF_WIDTH`, 7: reference window counter width. A window overflows after 2^REF_WIDTH−1 cycles.
- `EDGE_WIDTH`, 2: edge counter width. A measurement completes after 2^EDGE_WIDTH−1 edges.
- `STABLE_COUNT`, 2: number of consecutive identical results required before a commit. Legal range ≥1; 1 means commit immediately.
- `SYNC_STAGES`, 3: synchronizer depth on `meas_toggle`. Legal range ≥2.
- `clk`  in  1  reference clock (gtx_clk domain).
- `rst_n`  in  1  asynchronous active-low reset.
- `enable`  in  1  when low, measurement is held idle and the counters are cleared.
- `meas_toggle`  in  1  asynchronous toggle from the PHY rx domain (prescaler MSB).
- `speed`  out  2  committed speed: 00=10M, 01=100M, 10=1000M.
- `mii_select`  out  1  1 when the committed speed is 10M or 100M.
- `speed_valid`  out  1  a speed has been committed since reset or since the last loss.
- `speed_change`  out  1  one-cycle pulse on every commit that changes `speed` or sets `speed_valid`.
- `link_lost`  out  1  the rx clock is absent. Present only under the loss feature; otherwise tied 0.

## Operation
- `meas_toggle` passes through a `SYNC_STAGES` flop chain. An edge is the XOR of the last two stages.
- `ref_cnt` (REF_WIDTH bits) increments every enabled cycle. `edge_cnt` (EDGE_WIDTH bits) increments on each edge.
- A measurement ends in the cycle where `edge_cnt` or `ref_cnt` is all-ones. On that clock edge both counters clear.
- Classification:
  - `edge_cnt` all-ones: result is 100M if `ref_cnt[REF_WIDTH-1:REF_WIDTH-2]` is nonzero, otherwise 1000M.
  - Otherwise, `ref_cnt` overflow: result is 10M, or LOST under the loss feature when `edge_cnt`==0.
  - If both end conditions occur in the same cycle, the edge result wins.
- Agreement tracking:
  - If the result equals `cand`, `agree_cnt` increments, saturating at STABLE_COUNT.
  - Otherwise `cand` takes the new result and `agree_cnt` is set to 1.
- Commit happens when the next `agree_cnt` equals STABLE_COUNT and the result differs from the committed state:
  - Speed result: `speed`, `mii_select` and `speed_valid`=1 update, and `speed_change` pulses.
- Outputs never change except at a commit.
- `enable` low: counters and synchronizer-derived edge count cleared; `cand`/`agree_cnt` cleared to "no candidate". Committed outputs hold.
- Reset values: `speed`=10, `mii_select`=0, `speed_valid`=0, `speed_change`=0, `link_lost`=0. The reset also clears counters, `cand`, `agree_cnt` and the synchronizer.
- Counter width arithmetic: `agree_cnt` is $clog2(STABLE_COUNT+1) bits wide. There is no wrap; it saturates.

## Timing
- Edge detection latency is SYNC_STAGES cycles from the `meas_toggle` transition.
- Committed outputs are visible one cycle after the measurement-end cycle. `speed_change` is high for exactly that cycle.
- Minimum time to first commit is STABLE_COUNT measurement windows.
- Reset asserted mid-measurement returns all state to reset values immediately, without waiting for a clock edge. Measurement restarts on the first clock after `rst_n` deasserts.
- `enable` rising: the first window starts on that cycle with zeroed counters.

## Configuration
- `ETH_SPEED_DETECT_LOSS_EN` defined: LOSS is a distinct result code. A committed LOSS sets `link_lost`=1, clears `speed_valid`, holds `speed`/`mii_select`, and pulses `speed_change`. The next committed speed result clears `link_lost`.
- Not defined: a zero-edge overflow classifies as 10M, and `link_lost` is constant 0.

## Structure
- The shared package `eth_speed_pkg` holds:
  - the speed encodings SPEED_10M/100M/1000M;
  - the internal result enum, including RES_LOST and RES_NONE.
- The sub-module `eth_sync_bit` (parametrised depth, async active-low reset) implements the synchronizer. It is reused by other cross-domain status bits.

## Test plan
- 1000M: clk 8 ns, `meas_toggle` period 8 clk (an edge every 4 cycles), STABLE_COUNT=2 → `speed`=10, `mii_select`=0, `speed_valid`=1, and a single `speed_change` pulse after the second window.
- 100M: edge every 20 cycles → `speed`=01, `mii_select`=1 after 2 windows. A switch back to an edge every 4 cycles → `speed`=10 after exactly 2 further windows.
- 10M: edge every 200 cycles → windows overflow at `ref_cnt`=127, giving `speed`=00 and `mii_select`=1.
- Hysteresis: alternate single windows at 100M and 1000M rates with STABLE_COUNT=2 → no commit and no `speed_change` pulse.
- Loss, with the macro defined: stop `meas_toggle` after a 1000M lock → `link_lost`=1 and `speed_valid`=0 after 2 overflow windows, with `speed` still 10. Without the macro, the same stimulus gives `speed`=00.
- Assert `rst_n` mid-window, and separately drop `enable` → outputs return to reset values on reset; on `enable` low, outputs hold and the counters read zero.
